// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32 pipeline stage registers: stage state, per-boundary
// field structs and their widths.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 133;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_data_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } exmem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic [4:0]  rd;
  } memwb_data_t;

  function automatic logic [1:0] state_occ(input stage_state_e s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv_pipe_skid_buf.sv
// Two-entry skid control: state machine, skid register S and registered ready.
// state | meaning
// EMPTY | no beat held
// ONE   | beat in main register M
// FULL  | M and S both hold a beat; upstream is stalled
module rv_pipe_skid_buf
  import rv_pipe_pkg::*;
#(
  parameter int W = 136
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_accept,
  input  logic         i_deliver,
  input  logic [W-1:0] i_beat,
  output logic [1:0]   o_state,
  output logic         o_in_ready,
  output logic         o_load_in,
  output logic         o_load_skid,
  output logic [W-1:0] o_skid
);

  stage_state_e r_state;
  stage_state_e w_next;
  logic         r_in_ready;
  logic         w_load_s;
  logic [W-1:0] r_skid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != FULL);
    end
  end

  always_comb begin
    w_next      = r_state;
    o_load_in   = 1'b0;
    o_load_skid = 1'b0;
    w_load_s    = 1'b0;
    case (r_state)
      EMPTY: begin
        if (i_accept) begin
          w_next    = ONE;
          o_load_in = 1'b1;
        end
      end
      ONE: begin
        if (i_accept && i_deliver) begin
          o_load_in = 1'b1;
        end else if (i_accept) begin
          w_next   = FULL;
          w_load_s = 1'b1;
        end else if (i_deliver) begin
          w_next = EMPTY;
        end
      end
      FULL: begin
        if (i_deliver) begin
          w_next      = ONE;
          o_load_skid = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
    // Flush discards held beats and any beat arriving on the same edge.
    if (i_flush) begin
      w_next      = EMPTY;
      o_load_in   = 1'b0;
      o_load_skid = 1'b0;
      w_load_s    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid <= '0;
    end else if (w_load_s) begin
      r_skid <= i_beat;
    end
  end

  assign o_state    = r_state;
  assign o_in_ready = r_in_ready;
  assign o_skid     = r_skid;

endmodule

// File: rtl/rv_pipe_skid_stage.sv
// Flow-controlled pipeline stage register with optional skid buffer; control
// is masked to zero whenever no beat is presented, so empty stages are NOPs.
module rv_pipe_skid_stage
  import rv_pipe_pkg::*;
#(
  parameter int CTRL_W = $bits(memwb_ctrl_t),
  parameter int DATA_W = $bits(memwb_data_t),
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int BEAT_W = CTRL_W + DATA_W;

  logic [BEAT_W-1:0] w_in_beat;
  logic [BEAT_W-1:0] w_m_next;
  logic [BEAT_W-1:0] r_m;
  logic              w_load_m;
  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_deliver;
  logic [1:0]        w_occ;

  assign w_in_beat = {in_ctrl, in_data};
  assign w_accept  = in_valid & w_in_ready;
  assign w_deliver = w_out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [1:0]        w_state;
      logic              w_load_in;
      logic              w_load_skid;
      logic [BEAT_W-1:0] w_skid;

      rv_pipe_skid_buf #(.W(BEAT_W)) u_skid_buf (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (flush),
        .i_accept    (w_accept),
        .i_deliver   (w_deliver),
        .i_beat      (w_in_beat),
        .o_state     (w_state),
        .o_in_ready  (w_in_ready),
        .o_load_in   (w_load_in),
        .o_load_skid (w_load_skid),
        .o_skid      (w_skid)
      );

      assign w_out_valid = (stage_state_e'(w_state) != EMPTY);
      assign w_load_m    = w_load_in | w_load_skid;
      assign w_m_next    = w_load_skid ? w_skid : w_in_beat;
      assign w_occ       = state_occ(stage_state_e'(w_state));
    end else begin : g_noskid
      logic r_valid;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid <= 1'b0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_accept) begin
          r_valid <= 1'b1;
        end else if (w_deliver) begin
          r_valid <= 1'b0;
        end
      end

      assign w_in_ready  = !r_valid | out_ready;
      assign w_out_valid = r_valid;
      assign w_load_m    = w_accept & !flush;
      assign w_m_next    = w_in_beat;
      assign w_occ       = {1'b0, r_valid};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m <= '0;
    end else if (w_load_m) begin
      r_m <= w_m_next;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = w_out_valid ? r_m[BEAT_W-1 -: CTRL_W] : '0;
  assign out_data  = r_m[DATA_W-1:0];
  assign occupancy = w_occ;

endmodule

// File: tb/tb_rv_pipe_skid_stage.sv
// Scoreboard bench for rv_pipe_skid_stage, covering the SKID=1 and SKID=0 builds.
module tb_rv_pipe_skid_stage;
  import rv_pipe_pkg::*;

  localparam int CW = MEMWB_CTRL_W;
  localparam int DW = MEMWB_DATA_W;
  localparam int BW = CW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy0, val0, rdy1, val1;
  logic [CW-1:0] ctrl0, ctrl1;
  logic [DW-1:0] data0, data1;
  logic [1:0]    occ0, occ1;

  logic          m_rdy, m_val;
  logic [CW-1:0] m_ctrl;
  logic [DW-1:0] m_data;
  logic [1:0]    m_occ;

  int            sel = 0;
  logic [BW-1:0] q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_push = 0;
  int            n_pop = 0;

  always #5 clk = ~clk;

  rv_pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(val0), .out_ready(out_ready), .out_ctrl(ctrl0), .out_data(data0),
    .occupancy(occ0)
  );

  rv_pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(val1), .out_ready(out_ready), .out_ctrl(ctrl1), .out_data(data1),
    .occupancy(occ1)
  );

  assign m_rdy  = (sel == 0) ? rdy0  : rdy1;
  assign m_val  = (sel == 0) ? val0  : val1;
  assign m_ctrl = (sel == 0) ? ctrl0 : ctrl1;
  assign m_data = (sel == 0) ? data0 : data1;
  assign m_occ  = (sel == 0) ? occ0  : occ1;

  task automatic check_val(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One clock of stimulus: outputs are compared at the falling edge, then the
  // reference queue advances with the same accept/deliver rules.
  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input logic ordy, input logic fl);
    logic          exp_rdy, acc, del;
    logic [BW-1:0] hd;
    int            cnt;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    cnt     = q.size();
    exp_rdy = (sel == 0) ? (cnt < 2) : ((cnt == 0) || ordy);
    check_val("in_ready", BW'(m_rdy), BW'(exp_rdy));
    check_val("out_valid", BW'(m_val), BW'(cnt > 0));
    check_val("occupancy", BW'(m_occ), BW'(cnt));
    if (cnt > 0) begin
      hd = q[0];
      check_val("out_ctrl", BW'(m_ctrl), BW'(hd[BW-1 -: CW]));
      check_val("out_data", BW'(m_data), BW'(hd[DW-1:0]));
    end else begin
      check_val("bubble_ctrl", BW'(m_ctrl), '0);
    end
    acc = iv & exp_rdy;
    del = (cnt > 0) & ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (del) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (acc) begin
        q.push_back({ic, id});
        n_push++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 3'b111;
    in_data   = DW'(32'hDEAD);
    reset     = 1'b1;
    q.delete();
    n_push = 0;
    n_pop  = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", BW'(m_val), '0);
    check_val("rst_out_ctrl", BW'(m_ctrl), '0);
    check_val("rst_out_data", BW'(m_data), '0);
    check_val("rst_occupancy", BW'(m_occ), '0);
    check_val("rst_in_ready", BW'(m_rdy), BW'(1));
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // SKID=1 build
    sel = 0;
    do_reset();

    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);
    step(1'b1, 3'b101, DW'('h10), 1'b1, 1'b0);
    step(1'b1, 3'b101, DW'('h11), 1'b1, 1'b0);
    step(1'b1, 3'b101, DW'('h12), 1'b1, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);

    step(1'b1, 3'b101, DW'('hA), 1'b0, 1'b0);
    step(1'b1, 3'b101, DW'('hB), 1'b0, 1'b0);
    step(1'b1, 3'b101, DW'('hC), 1'b0, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b0, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);

    step(1'b1, 3'b001, DW'('hA0), 1'b0, 1'b0);
    step(1'b1, 3'b001, DW'('hA1), 1'b0, 1'b0);
    step(1'b1, 3'b111, DW'('hA2), 1'b0, 1'b1);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);

    step(1'b1, 3'b001, DW'('hB0), 1'b1, 1'b0);
    step(1'b1, 3'b001, DW'('hB1), 1'b1, 1'b1);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);

    step(1'b0, 3'b111, DW'('hFF), 1'b1, 1'b0);
    step(1'b0, 3'b111, DW'('hFF), 1'b0, 1'b0);
    step(1'b0, 3'b111, DW'('hFF), 1'b1, 1'b0);

    step(1'b1, 3'b101, DW'('hC0), 1'b0, 1'b0);
    step(1'b1, 3'b101, DW'('hC1), 1'b0, 1'b0);
    check_val("full_before_reset", BW'(m_occ), BW'(2));
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("async_out_valid", BW'(m_val), '0);
    check_val("async_out_ctrl", BW'(m_ctrl), '0);
    check_val("async_occupancy", BW'(m_occ), '0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 3'b010, DW'('h55), 1'b1, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);
    step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);

    // SKID=0 build
    sel = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 3'b110, DW'(32'h200 + i), ((i % 3) != 1), 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b000, DW'(0), 1'b1, 1'b0);
    end
    check_val("noskid_all_delivered", BW'(n_pop), BW'(n_push));
    check_val("noskid_queue_empty", BW'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_pipe_skid_stage.md
Name: rv_pipe_skid_stage

Overview:
- Parametrised, flow-controlled pipeline stage register for the RV32 five-stage core.
- Generic successor to the fixed-field stage registers: any boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) packs its fields into a ctrl bus and a data bus.
- Adds a valid/ready handshake, stall via backpressure, synchronous flush to bubble, and an optional 2-entry skid buffer that removes the combinational ready path.
- Bubbles always present all-zero control (RegWrite=0, MemWrite=0), so a flushed or empty stage is a NOP.

Parameters:
- CTRL_W, default 3: control-field width; cleared on flush and whenever out_valid=0.
- DATA_W, default 133: datapath payload width; not cleared on flush.
- SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous flush; discards all held and incoming beats.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: stage can accept a beat.
- in_ctrl, input, CTRL_W: upstream control fields.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: downstream beat valid.
- out_ready, input, 1: downstream accepts; 0 = stall.
- out_ctrl, output, CTRL_W: control to next stage; 0 whenever out_valid=0.
- out_data, output, DATA_W: payload to next stage.
- occupancy, output, 2: beats held (0..2; max 1 when SKID=0).

Behaviour:
- Clock/reset: clk drives the stage. reset is asynchronous, active-high.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, state EMPTY, skid entry cleared. in_ready is 1 after reset; beats offered while reset is high are ignored.
- Transfers: accept = in_valid & in_ready. Deliver = out_valid & out_ready. Both are evaluated on the same clock edge.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY. Throughput is 1 beat/cycle while out_ready=1.
- SKID=1 state machine (main register M, skid register S):
  - EMPTY: accept -> ONE, M<=in.
  - ONE:
    - accept & deliver -> ONE, M<=in.
    - accept & !deliver -> FULL, S<=in.
    - !accept & deliver -> EMPTY.
    - otherwise hold.
  - FULL: deliver -> ONE, M<=S. No accept is possible, since in_ready=0.
  - in_ready is registered and equals (next_state != FULL). It never depends combinationally on out_ready.
  - out_valid=1 in ONE and FULL. out_ctrl/out_data come from M.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - accept loads M and sets out_valid.
  - deliver without accept clears out_valid.
  - The state machine degenerates to EMPTY/ONE.
- Ordering: beats leave in acceptance order. None are duplicated or dropped except by flush.
- Flush (highest priority after reset):
  - On a clock edge with flush=1: state -> EMPTY, out_valid=0, out_ctrl=0, and the S valid bit is cleared.
  - A beat accepted on the same edge is discarded.
  - out_data is not required to clear.
  - in_ready=1 on the following cycle.
- Bubble masking: out_ctrl is forced to 0 whenever out_valid=0, regardless of M contents.
- Stall: with out_ready=0, M and S are held bit-exact. out_data must not change while out_valid=1 and out_ready=0.
- Reset mid-operation: held beats are lost immediately (asynchronous). No output glitches to a nonzero ctrl value.
- in_ctrl/in_data are sampled only on accept and may be X otherwise. X on them must not reach the outputs while out_valid=0.

Decomposition:
- Shared package rv_pipe_pkg:
  - stage state enum {EMPTY, ONE, FULL}.
  - per-boundary ctrl/data packed-struct typedefs.
  - width constants: MEMWB_CTRL_W=3, MEMWB_DATA_W=133 (ALUResult, ReadData, PCPlus4, PCTarget = 4x32, plus Rd=5).
- The top-level stage is instantiated with $bits of the structs.
- Natural sub-module: rv_pipe_skid_buf, which holds the S register and the state machine. The top handles masking, flush and the SKID=0 path.

Test Plan:
- Reset then stream: in_valid=1 with ctrl=3'b101, data=0x10,0x11,0x12 on consecutive cycles, out_ready=1 -> out beats appear one cycle later, in order, at 1/cycle; occupancy=1.
- Stall fill: ONE holding 0xA, out_ready=0, offer 0xB -> FULL, in_ready=0 next cycle, out_data stays 0xA. Release out_ready -> 0xA then 0xB delivered; in_ready returns to 1 after 0xA leaves.
- Flush while FULL with a simultaneous accept attempt -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; no beat delivered afterwards.
- Bubble masking: with the stage EMPTY, drive in_ctrl=3'b111 and in_valid=0 -> out_ctrl stays 0 and out_valid stays 0.
- Async reset asserted mid-cycle while FULL -> out_valid and out_ctrl are 0 immediately, before the next clk edge. After release, a fresh beat 0x55 passes with 1-cycle latency.
- SKID=0 build: out_ready toggles 1,0,1 under continuous input -> in_ready equals !out_valid|out_ready in the same cycle; occupancy never exceeds 1; no beat is lost.
